// File: rtl/bp_be_pkg.sv
// Shared backend constants and the issue-entry declare macro.
// Dual issue is enabled by defining BP_BE_DUAL_ISSUE_EN.
`define DECLARE_BP_BE_ISSUE_ENTRY_S(instr_width_mp) \
    typedef struct packed { \
        logic [instr_width_mp-1:0] instr; \
        logic [1:0] rs_v; \
        logic [1:0][bp_be_pkg::reg_addr_width_gp-1:0] rs; \
        logic rd_w_v; \
        logic [bp_be_pkg::reg_addr_width_gp-1:0] rd; \
        logic serial; \
    } bp_be_issue_entry_s

package bp_be_pkg;

    localparam int reg_addr_width_gp = 5;
    localparam int issue_width_gp = 2;

    function automatic int issue_entry_width(input int instr_width);
        return instr_width + 2 + 2 * reg_addr_width_gp + 1
               + reg_addr_width_gp + 1;
    endfunction

endpackage

// File: rtl/bp_be_issue_queue_di_if.sv
// Enqueue handshake bundle for the dual-issue issue queue.
// Dual issue is enabled by defining BP_BE_DUAL_ISSUE_EN.
interface bp_be_issue_queue_di_if #(
    parameter int instr_width_p = 64
);
    import bp_be_pkg::*;

    logic                              enq_v_i;
    logic                              enq_ready_o;
    logic [instr_width_p-1:0]          enq_instr_i;
    logic [1:0]                        enq_rs_v_i;
    logic [1:0][reg_addr_width_gp-1:0] enq_rs_i;
    logic                              enq_rd_w_v_i;
    logic [reg_addr_width_gp-1:0]      enq_rd_i;
    logic                              enq_serial_i;

    modport master (
        output enq_v_i, enq_instr_i, enq_rs_v_i, enq_rs_i,
        output enq_rd_w_v_i, enq_rd_i, enq_serial_i,
        input  enq_ready_o
    );

    modport slave (
        input  enq_v_i, enq_instr_i, enq_rs_v_i, enq_rs_i,
        input  enq_rd_w_v_i, enq_rd_i, enq_serial_i,
        output enq_ready_o
    );

endinterface

// File: rtl/bp_be_issue_pair_check.sv
// Combinational issue decision for the two oldest queue slots.
// Slot 1 issue exists only when BP_BE_DUAL_ISSUE_EN is defined.
module bp_be_issue_pair_check
    import bp_be_pkg::*;
#(
    parameter int instr_width_p = 64,
    parameter int cnt_width_p   = 3,
    localparam int entry_w_lp   = issue_entry_width(instr_width_p)
) (
    input  logic [entry_w_lp-1:0]     slot0_i,
    input  logic [entry_w_lp-1:0]     slot1_i,
    input  logic [1:0]                sb_rs_match_i1,
    input  logic [1:0]                sb_rs_match_i2,
    input  logic                      sb_rd_match_i1,
    input  logic                      sb_rd_match_i2,
    input  logic [cnt_width_p-1:0]    count_i,
    input  logic                      issue_ready_i,
    output logic [issue_width_gp-1:0] issue_v_o
);

    `DECLARE_BP_BE_ISSUE_ENTRY_S(instr_width_p);

    bp_be_issue_entry_s s0, s1;
    logic haz0, haz1, v0;

    assign s0 = slot0_i;
    assign s1 = slot1_i;

    // The scoreboard reports x0 hits too, so mask by address and use flags
    assign haz0 = (|(sb_rs_match_i1 & s0.rs_v & {|s0.rs[1], |s0.rs[0]}))
                | (sb_rd_match_i1 & s0.rd_w_v & (|s0.rd));
    assign haz1 = (|(sb_rs_match_i2 & s1.rs_v & {|s1.rs[1], |s1.rs[0]}))
                | (sb_rd_match_i2 & s1.rd_w_v & (|s1.rd));

    assign v0 = (count_i != '0) & issue_ready_i & ~haz0;
    assign issue_v_o[0] = v0;

`ifdef BP_BE_DUAL_ISSUE_EN
    logic unused_instr;
    assign unused_instr = ^{s0.instr, s1.instr};
    assign issue_v_o[1] = v0 & (count_i >= cnt_width_p'(2))
                        & ~s0.serial & ~s1.serial & ~haz1;
`else
    logic unused_slot1;
    assign unused_slot1 = ^{s0.instr, s0.serial, s1, haz1};
    assign issue_v_o[1] = 1'b0;
`endif

endmodule

// File: rtl/bp_be_issue_queue_di.sv
// In-order issue queue feeding the dual-issue scoreboard.
// Define BP_BE_DUAL_ISSUE_EN to allow two issues per cycle.
module bp_be_issue_queue_di
    import bp_be_pkg::*;
#(
    parameter int els_p         = 4,
    parameter int instr_width_p = 64
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    bp_be_issue_queue_di_if.slave             enq_if,
    input  logic                              flush_i,
    output logic [1:0][reg_addr_width_gp-1:0] sb_rs_o1,
    output logic [1:0][reg_addr_width_gp-1:0] sb_rs_o2,
    output logic [reg_addr_width_gp-1:0]      sb_rd_o1,
    output logic [reg_addr_width_gp-1:0]      sb_rd_o2,
    input  logic [1:0]                        sb_rs_match_i1,
    input  logic [1:0]                        sb_rs_match_i2,
    input  logic                              sb_rd_match_i1,
    input  logic                              sb_rd_match_i2,
    input  logic                              issue_ready_i,
    output logic [issue_width_gp-1:0]         issue_v_o,
    output logic [issue_width_gp-1:0][instr_width_p-1:0] issue_instr_o,
    output logic                              score_v_o1,
    output logic                              score_v_o2,
    output logic [reg_addr_width_gp-1:0]      score_rd_o1,
    output logic [reg_addr_width_gp-1:0]      score_rd_o2
);

    localparam int ptr_w_lp = $clog2(els_p);
    localparam int cnt_w_lp = $clog2(els_p + 1);

    `DECLARE_BP_BE_ISSUE_ENTRY_S(instr_width_p);

    bp_be_issue_entry_s mem_q [els_p];
    bp_be_issue_entry_s slot0, slot1, enq_entry;

    logic [ptr_w_lp-1:0] rptr_q, rptr_d, wptr_q, wptr_d, rptr_p1;
    logic [cnt_w_lp-1:0] count_q, count_d, n_iss;
    logic [issue_width_gp-1:0] pair_v;
    logic enq_ready, enq_fire;

    assign rptr_p1 = rptr_q + ptr_w_lp'(1);
    assign slot0   = mem_q[rptr_q];
    assign slot1   = mem_q[rptr_p1];

    // Readiness uses registered count only, so a full queue never takes
    // an entry even while it is issuing
    assign enq_ready = (count_q != cnt_w_lp'(els_p));
    assign enq_fire  = enq_if.enq_v_i & enq_ready & ~flush_i;
    assign enq_if.enq_ready_o = enq_ready;

    assign enq_entry = '{
        instr:  enq_if.enq_instr_i,
        rs_v:   enq_if.enq_rs_v_i,
        rs:     enq_if.enq_rs_i,
        rd_w_v: enq_if.enq_rd_w_v_i,
        rd:     enq_if.enq_rd_i,
        serial: enq_if.enq_serial_i
    };

    bp_be_issue_pair_check #(
        .instr_width_p (instr_width_p),
        .cnt_width_p   (cnt_w_lp)
    ) u_pair (
        .slot0_i        (slot0),
        .slot1_i        (slot1),
        .sb_rs_match_i1 (sb_rs_match_i1),
        .sb_rs_match_i2 (sb_rs_match_i2),
        .sb_rd_match_i1 (sb_rd_match_i1),
        .sb_rd_match_i2 (sb_rd_match_i2),
        .count_i        (count_q),
        .issue_ready_i  (issue_ready_i),
        .issue_v_o      (pair_v)
    );

    assign issue_v_o = flush_i ? '0 : pair_v;
    assign n_iss = cnt_w_lp'(issue_v_o[0]) + cnt_w_lp'(issue_v_o[1]);

    assign sb_rs_o1 = slot0.rs;
    assign sb_rs_o2 = slot1.rs;
    assign sb_rd_o1 = slot0.rd;
    assign sb_rd_o2 = slot1.rd;

    assign issue_instr_o[0] = slot0.instr;
    assign issue_instr_o[1] = slot1.instr;

    assign score_v_o1  = issue_v_o[0] & slot0.rd_w_v & (|slot0.rd);
    assign score_v_o2  = issue_v_o[1] & slot1.rd_w_v & (|slot1.rd);
    assign score_rd_o1 = slot0.rd;
    assign score_rd_o2 = slot1.rd;

    always_comb begin
        rptr_d  = rptr_q + ptr_w_lp'(n_iss);
        wptr_d  = wptr_q + ptr_w_lp'(enq_fire);
        count_d = count_q + cnt_w_lp'(enq_fire) - n_iss;
        if (flush_i) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    // Payload storage carries no reset; validity comes from count
    always_ff @(posedge clk_i) begin
        if (enq_fire) begin
            mem_q[wptr_q] <= enq_entry;
        end
    end

endmodule
